// File: rtl/sync_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sync_mem_pkg
// Purpose  : Shared sizing constants for the forwarding register-file memory.
// Revision : 1.0 - initial release
// ============================================================================
package sync_mem_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 4;
    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_DEPTH      = 2 ** DEFAULT_ADDR_WIDTH;

    function automatic int mem_depth(input int addr_width);
        return 2 ** addr_width;
    endfunction

endpackage : sync_mem_pkg
`default_nettype wire

// File: rtl/sync_mem_array.sv
`default_nettype none
// ============================================================================
// Module   : sync_mem_array
// Purpose  : Storage array with synchronous clear, one write port and an
//            asynchronous read of the pre-edge contents.
// Revision : 1.0 - initial release
// ============================================================================
module sync_mem_array
    import sync_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    localparam int DEPTH = mem_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Reset has priority, so a write presented during reset is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule : sync_mem_array
`default_nettype wire

// File: rtl/sync_mem_rd_fwd.sv
`default_nettype none
// ============================================================================
// Module   : sync_mem_rd_fwd
// Purpose  : Register-file memory with registered read and write-to-read
//            forwarding. Define SYNC_MEM_FWD_FLAG_EN to add rd_fwd_hit.
// Revision : 1.0 - initial release
// ============================================================================
module sync_mem_rd_fwd
    import sync_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] wr_addr_in,
    input  logic [DATA_WIDTH-1:0] wr_data_in,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr_in,
`ifdef SYNC_MEM_FWD_FLAG_EN
    output logic                  rd_fwd_hit,
`endif
    output logic [DATA_WIDTH-1:0] rd_data_out
);

    logic [DATA_WIDTH-1:0] w_array_rd;
    logic                  w_fwd;
    logic [DATA_WIDTH-1:0] rd_data_d;
    logic [DATA_WIDTH-1:0] rd_data_q;

    sync_mem_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr_in),
        .wr_data_i  (wr_data_in),
        .rd_addr_i  (rd_addr_in),
        .rd_data_o  (w_array_rd)
    );

    // A same-edge write to the read address must win over the stale entry.
    assign w_fwd     = wr_en && (wr_addr_in == rd_addr_in);
    assign rd_data_d = w_fwd ? wr_data_in : w_array_rd;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_out = rd_data_q;

`ifdef SYNC_MEM_FWD_FLAG_EN
    logic fwd_hit_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_hit_q <= 1'b0;
        end else begin
            fwd_hit_q <= w_fwd;
        end
    end

    assign rd_fwd_hit = fwd_hit_q;
`endif

endmodule : sync_mem_rd_fwd
`default_nettype wire

// File: tb/tb_sync_mem_rd_fwd.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_mem_rd_fwd
// Purpose  : Directed scoreboard bench for sync_mem_rd_fwd.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_mem_rd_fwd;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] wr_addr_in;
    logic [7:0] wr_data_in;
    logic       wr_en;
    logic [3:0] rd_addr_in;
    logic [7:0] rd_data_out;
    logic       hit_w;

`ifdef SYNC_MEM_FWD_FLAG_EN
    logic rd_fwd_hit;
    assign hit_w = rd_fwd_hit;
`else
    assign hit_w = 1'b0;
`endif

    sync_mem_rd_fwd #(
        .ADDR_WIDTH (4),
        .DATA_WIDTH (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_addr_in  (wr_addr_in),
        .wr_data_in  (wr_data_in),
        .wr_en       (wr_en),
        .rd_addr_in  (rd_addr_in),
`ifdef SYNC_MEM_FWD_FLAG_EN
        .rd_fwd_hit  (rd_fwd_hit),
`endif
        .rd_data_out (rd_data_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       hit;
        logic [7:0] id;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests  = 0;
    int   n_failed = 0;
    logic done     = 1'b0;

    // One expected entry per clock edge, consumed just after that edge.
    task automatic step(input logic r, input logic we, input logic [3:0] wa,
                        input logic [7:0] wd, input logic [3:0] ra,
                        input logic [7:0] ed, input logic eh, input logic [7:0] id);
        exp_t e;
        rst        = r;
        wr_en      = we;
        wr_addr_in = wa;
        wr_data_in = wd;
        rd_addr_in = ra;
        e.data = ed;
        e.hit  = eh;
        e.id   = id;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (rd_data_out !== e.data) begin
                    n_failed++;
                    $display("FAIL rd_data step %0d: got %02h expected %02h", e.id, rd_data_out, e.data);
                end
`ifdef SYNC_MEM_FWD_FLAG_EN
                n_tests++;
                if (hit_w !== e.hit) begin
                    n_failed++;
                    $display("FAIL fwd_hit step %0d: got %0b expected %0b", e.id, hit_w, e.hit);
                end
`endif
            end
        end
    end

    initial begin : stim
        //    rst we  wa    wd     ra    exp    hit id
        step(1, 1, 4'h9, 8'h55, 4'h3, 8'h00, 0, 1);   // reset, write ignored
        step(0, 0, 4'h0, 8'h00, 4'h3, 8'h00, 0, 2);
        step(0, 1, 4'hA, 8'hAA, 4'h3, 8'h00, 0, 3);
        step(0, 1, 4'h0, 8'hCC, 4'h3, 8'h00, 0, 4);
        step(0, 0, 4'h0, 8'h00, 4'h0, 8'hCC, 0, 5);
        step(0, 0, 4'h0, 8'h00, 4'hA, 8'hAA, 0, 6);
        step(0, 1, 4'h5, 8'h11, 4'h0, 8'hCC, 0, 7);   // write elsewhere
        step(0, 0, 4'h0, 8'h00, 4'h5, 8'h11, 0, 8);
        step(0, 1, 4'h5, 8'hFF, 4'h5, 8'hFF, 1, 9);   // collision forwards
        step(0, 0, 4'h0, 8'h00, 4'h5, 8'hFF, 0, 10);
        step(0, 0, 4'h5, 8'h77, 4'h5, 8'hFF, 0, 11);  // disabled write
        step(0, 0, 4'h0, 8'h00, 4'h5, 8'hFF, 0, 12);
        step(0, 1, 4'h3, 8'h22, 4'h3, 8'h22, 1, 13);
        step(0, 1, 4'h3, 8'h33, 4'hA, 8'hAA, 0, 14);  // last write wins
        step(0, 0, 4'h0, 8'h00, 4'h3, 8'h33, 0, 15);
        step(1, 1, 4'h9, 8'h55, 4'h9, 8'h00, 0, 16);  // mid-run reset
        step(0, 0, 4'h0, 8'h00, 4'h9, 8'h00, 0, 17);
        step(0, 0, 4'h0, 8'h00, 4'hA, 8'h00, 0, 18);
        step(0, 0, 4'h0, 8'h00, 4'h5, 8'h00, 0, 19);
        step(0, 1, 4'hF, 8'h5A, 4'h0, 8'h00, 0, 20);  // top address
        step(0, 0, 4'h0, 8'h00, 4'hF, 8'h5A, 0, 21);
        wr_en = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_failed++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        done = 1'b1;
    end

    initial begin : finisher
        fork
            wait (done);
            #5000;
        join_any
        if (!done) begin
            n_tests++;
            n_failed++;
            $display("FAIL timeout: got no completion expected completion");
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule : tb_sync_mem_rd_fwd
`default_nettype wire
